// File: rtl/hdd_usrcfg_arb_if.sv
// User command channel bundle between the two masters and the HDD core port.
// slave = arbiter side, master = camera/debug/core side.
interface hdd_usrcfg_arb_if;
  logic        p_in_cam_wr;
  logic [15:0] p_in_cam_txd;
  logic        p_in_cam_rd;
  logic [15:0] p_out_cam_rxd;
  logic        p_out_cam_busy;
  logic        p_in_dbg_wr;
  logic [15:0] p_in_dbg_txd;
  logic        p_in_dbg_rd;
  logic [15:0] p_out_dbg_rxd;
  logic        p_out_dbg_busy;
  logic        p_out_usr_tx_wr;
  logic [15:0] p_out_usr_txd;
  logic        p_out_usr_rx_rd;
  logic [15:0] p_in_usr_rxd;
  logic [1:0]  p_out_owner;
  logic        p_out_err;

  modport slave (
    input  p_in_cam_wr, p_in_cam_txd, p_in_cam_rd,
    input  p_in_dbg_wr, p_in_dbg_txd, p_in_dbg_rd,
    input  p_in_usr_rxd,
    output p_out_cam_rxd, p_out_cam_busy,
    output p_out_dbg_rxd, p_out_dbg_busy,
    output p_out_usr_tx_wr, p_out_usr_txd,
    output p_out_usr_rx_rd,
    output p_out_owner, p_out_err
  );

  modport master (
    output p_in_cam_wr, p_in_cam_txd, p_in_cam_rd,
    output p_in_dbg_wr, p_in_dbg_txd, p_in_dbg_rd,
    output p_in_usr_rxd,
    input  p_out_cam_rxd, p_out_cam_busy,
    input  p_out_dbg_rxd, p_out_dbg_busy,
    input  p_out_usr_tx_wr, p_out_usr_txd,
    input  p_out_usr_rx_rd,
    input  p_out_owner, p_out_err
  );
endinterface

// File: rtl/hdd_usrcfg_arb.sv
// Round-robin camera/debug arbiter for the HDD user command channel.
// Define HDD_USRCFG_ARB_TIMEOUT_EN to enable the in-packet idle watchdog.
module hdd_usrcfg_arb #(
  parameter int unsigned G_TIMEOUT = 1024
) (
  input logic             p_in_clk,
  input logic             p_in_rst_n,
  hdd_usrcfg_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    XFER
  } state_e;

  if (G_TIMEOUT < 2 || G_TIMEOUT > 65535) begin : g_bad_to
    $error("G_TIMEOUT out of range");
  end

  state_e      state_q, state_d;
  logic        cam_v_q, cam_v_d;
  logic        dbg_v_q, dbg_v_d;
  logic [15:0] cam_hold_q, cam_hold_d;
  logic [15:0] dbg_hold_q, dbg_hold_d;
  logic        gnt_q, gnt_d;
  logic        dir_q, dir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tx_wr_q, tx_wr_d;
  logic [15:0] txd_q, txd_d;
  logic        rx_rd_q, rx_rd_d;

  logic        owned, own_cam, own_dbg;
  logic        own_wr, own_rd, acc, pick_dbg;
  logic [15:0] own_txd;
  logic        cam_sel, dbg_sel;

`ifdef HDD_USRCFG_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(G_TIMEOUT - 1);
  logic [15:0] idle_q, idle_d;
  logic        err_q, err_d;
`endif

  assign owned   = (state_q != IDLE);
  assign own_cam = owned && !gnt_q;
  assign own_dbg = owned && gnt_q;
  assign own_wr  = gnt_q ? bus.p_in_dbg_wr : bus.p_in_cam_wr;
  assign own_rd  = gnt_q ? bus.p_in_dbg_rd : bus.p_in_cam_rd;
  assign own_txd = gnt_q ? bus.p_in_dbg_txd : bus.p_in_cam_txd;
  assign acc     = owned && (cnt_q != 8'd0) &&
                   (dir_q ? own_rd : own_wr);

  // gnt_q doubles as the last-owner flag for round-robin
  assign pick_dbg = dbg_v_q && !(cam_v_q && gnt_q);

  always_comb begin
    state_d    = state_q;
    cam_v_d    = cam_v_q;
    dbg_v_d    = dbg_v_q;
    cam_hold_d = cam_hold_q;
    dbg_hold_d = dbg_hold_q;
    gnt_d      = gnt_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    tx_wr_d    = 1'b0;
    txd_d      = txd_q;
    rx_rd_d    = 1'b0;
`ifdef HDD_USRCFG_ARB_TIMEOUT_EN
    idle_d     = 16'd0;
    err_d      = 1'b0;
`endif

    if (bus.p_in_cam_wr && !cam_v_q && !own_cam) begin
      cam_v_d    = 1'b1;
      cam_hold_d = bus.p_in_cam_txd;
    end
    if (bus.p_in_dbg_wr && !dbg_v_q && !own_dbg) begin
      dbg_v_d    = 1'b1;
      dbg_hold_d = bus.p_in_dbg_txd;
    end

    unique case (state_q)
      IDLE: begin
        if (cam_v_q || dbg_v_q) begin
          gnt_d   = pick_dbg;
          tx_wr_d = 1'b1;
          txd_d   = pick_dbg ? dbg_hold_q : cam_hold_q;
          dir_d   = txd_d[15];
          cnt_d   = txd_d[7:0];
          state_d = HDR;
        end
      end
      HDR, XFER: begin
        if (state_q == HDR) begin
          if (gnt_q) dbg_v_d = 1'b0;
          else       cam_v_d = 1'b0;
        end
        if (acc) begin
          cnt_d = cnt_q - 8'd1;
          if (dir_q) begin
            rx_rd_d = 1'b1;
          end else begin
            tx_wr_d = 1'b1;
            txd_d   = own_txd;
          end
        end
        state_d = (cnt_d == 8'd0) ? IDLE : XFER;
`ifdef HDD_USRCFG_ARB_TIMEOUT_EN
        if (state_q == XFER && !acc) begin
          if (idle_q == TO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            idle_d = idle_q + 16'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge p_in_clk) begin
    if (!p_in_rst_n) begin
      state_q    <= IDLE;
      cam_v_q    <= 1'b0;
      dbg_v_q    <= 1'b0;
      cam_hold_q <= 16'd0;
      dbg_hold_q <= 16'd0;
      gnt_q      <= 1'b1;
      dir_q      <= 1'b0;
      cnt_q      <= 8'd0;
      tx_wr_q    <= 1'b0;
      txd_q      <= 16'd0;
      rx_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cam_v_q    <= cam_v_d;
      dbg_v_q    <= dbg_v_d;
      cam_hold_q <= cam_hold_d;
      dbg_hold_q <= dbg_hold_d;
      gnt_q      <= gnt_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      tx_wr_q    <= tx_wr_d;
      txd_q      <= txd_d;
      rx_rd_q    <= rx_rd_d;
    end
  end

`ifdef HDD_USRCFG_ARB_TIMEOUT_EN
  always_ff @(posedge p_in_clk) begin
    if (!p_in_rst_n) begin
      idle_q <= 16'd0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end
  assign bus.p_out_err = err_q;
`else
  assign bus.p_out_err = 1'b0;
`endif

  // read data stays routed for the strobe that closes the packet
  assign cam_sel = own_cam || (rx_rd_q && !gnt_q);
  assign dbg_sel = own_dbg || (rx_rd_q && gnt_q);

  assign bus.p_out_cam_rxd   = cam_sel ? bus.p_in_usr_rxd : 16'd0;
  assign bus.p_out_dbg_rxd   = dbg_sel ? bus.p_in_usr_rxd : 16'd0;
  assign bus.p_out_cam_busy  = cam_v_q && !own_cam;
  assign bus.p_out_dbg_busy  = dbg_v_q && !own_dbg;
  assign bus.p_out_usr_tx_wr = tx_wr_q;
  assign bus.p_out_usr_txd   = txd_q;
  assign bus.p_out_usr_rx_rd = rx_rd_q;
  assign bus.p_out_owner     = own_cam ? 2'b01 :
                               own_dbg ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_hdd_usrcfg_arb.sv
// Bench for hdd_usrcfg_arb: scoreboard of forwarded words plus direct checks.
// Timeout scenario follows HDD_USRCFG_ARB_TIMEOUT_EN.
module tb_hdd_usrcfg_arb;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hdd_usrcfg_arb_if bus ();

  hdd_usrcfg_arb #(
    .G_TIMEOUT(TO)
  ) u_dut (
    .p_in_clk  (clk),
    .p_in_rst_n(rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input bit m, input logic wr,
                       input logic rd, input logic [15:0] d);
    if (m) begin
      bus.p_in_dbg_wr  = wr;
      bus.p_in_dbg_rd  = rd;
      bus.p_in_dbg_txd = d;
    end else begin
      bus.p_in_cam_wr  = wr;
      bus.p_in_cam_rd  = rd;
      bus.p_in_cam_txd = d;
    end
  endtask

  task automatic wait_owner(input logic [1:0] code);
    int k = 0;
    while (bus.p_out_owner != code && k < 40) begin
      tick;
      k++;
    end
    chk("grant_wait", bus.p_out_owner, code);
  endtask

  task automatic send_wr(input bit m, input logic [15:0] hdr,
                         input logic [15:0] base);
    int n;
    n = int'(hdr[7:0]);
    set_m(m, 1'b1, 1'b0, hdr);
    exp_q.push_back(hdr);
    tick;
    set_m(m, 1'b0, 1'b0, 16'd0);
    wait_owner(m ? 2'b10 : 2'b01);
    for (int i = 0; i < n; i++) begin
      set_m(m, 1'b1, 1'b0, base + 16'(i));
      exp_q.push_back(base + 16'(i));
      tick;
    end
    set_m(m, 1'b0, 1'b0, 16'd0);
    chk("pkt_done", bus.p_out_owner, 2'b00);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txwr"}, bus.p_out_usr_tx_wr, 0);
    chk({tag, "_txd"}, bus.p_out_usr_txd, 0);
    chk({tag, "_rxrd"}, bus.p_out_usr_rx_rd, 0);
    chk({tag, "_owner"}, bus.p_out_owner, 0);
    chk({tag, "_err"}, bus.p_out_err, 0);
    chk({tag, "_cbusy"}, bus.p_out_cam_busy, 0);
    chk({tag, "_dbusy"}, bus.p_out_dbg_busy, 0);
    chk({tag, "_crxd"}, bus.p_out_cam_rxd, 0);
    chk({tag, "_drxd"}, bus.p_out_dbg_rxd, 0);
  endtask

  // every forwarded word must match the next expected one
  always @(negedge clk) begin
    if (bus.p_out_usr_tx_wr === 1'b1) begin
      if (exp_q.size() == 0)
        chk("tx_extra", exp_q.size(), 1);
      else
        chk("txd", bus.p_out_usr_txd, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int first;
    int pulses;
    logic [1:0] own_at_err;
    set_m(0, 1'b0, 1'b0, 16'd0);
    set_m(1, 1'b0, 1'b0, 16'd0);
    bus.p_in_usr_rxd = 16'hFFFF;
    repeat (3) tick;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    bus.p_in_usr_rxd = 16'h0000;
    tick;

    // simultaneous headers right after reset: camera first
    set_m(0, 1'b1, 1'b0, 16'h0002);
    set_m(1, 1'b1, 1'b0, 16'h0001);
    exp_q.push_back(16'h0002);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    set_m(1, 1'b0, 1'b0, 16'd0);
    chk("tie_cbusy1", bus.p_out_cam_busy, 1);
    chk("tie_dbusy1", bus.p_out_dbg_busy, 1);
    chk("tie_own0", bus.p_out_owner, 2'b00);
    tick;
    chk("tie_own_cam", bus.p_out_owner, 2'b01);
    chk("tie_cbusy2", bus.p_out_cam_busy, 0);
    chk("tie_hdr_wr", bus.p_out_usr_tx_wr, 1);
    set_m(0, 1'b1, 1'b0, 16'hC001);
    exp_q.push_back(16'hC001);
    tick;
    set_m(0, 1'b1, 1'b0, 16'hC002);
    exp_q.push_back(16'hC002);
    chk("tie_dbusy3", bus.p_out_dbg_busy, 1);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    exp_q.push_back(16'h0001);
    chk("tie_idle", bus.p_out_owner, 2'b00);
    chk("tie_dbusy4", bus.p_out_dbg_busy, 1);
    tick;
    chk("tie_own_dbg", bus.p_out_owner, 2'b10);
    chk("tie_dbusy5", bus.p_out_dbg_busy, 0);
    chk("tie_dhdr_wr", bus.p_out_usr_tx_wr, 1);
    set_m(1, 1'b1, 1'b0, 16'hD001);
    exp_q.push_back(16'hD001);
    tick;
    set_m(1, 1'b0, 1'b0, 16'd0);
    chk("tie_done", bus.p_out_owner, 2'b00);
    tick;

    // camera write packet, header plus 3 words
    set_m(0, 1'b1, 1'b0, 16'h0003);
    exp_q.push_back(16'h0003);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    chk("wr_busy", bus.p_out_cam_busy, 1);
    chk("wr_txwr0", bus.p_out_usr_tx_wr, 0);
    tick;
    chk("wr_own", bus.p_out_owner, 2'b01);
    chk("wr_txwr_h", bus.p_out_usr_tx_wr, 1);
    chk("wr_nobusy", bus.p_out_cam_busy, 0);
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1'b1, 1'b0, 16'hA000 + 16'(i));
      exp_q.push_back(16'hA000 + 16'(i));
      tick;
      chk("wr_txwr_p", bus.p_out_usr_tx_wr, 1);
    end
    set_m(0, 1'b0, 1'b0, 16'd0);
    chk("wr_end_own", bus.p_out_owner, 2'b00);
    tick;
    chk("wr_after", bus.p_out_usr_tx_wr, 0);

    // debug read packet with stray strobes
    set_m(1, 1'b1, 1'b0, 16'h8002);
    exp_q.push_back(16'h8002);
    tick;
    set_m(1, 1'b0, 1'b0, 16'd0);
    wait_owner(2'b10);
    set_m(1, 1'b0, 1'b1, 16'd0);
    tick;
    chk("rd_rx1", bus.p_out_usr_rx_rd, 1);
    bus.p_in_usr_rxd = 16'hA5A5;
    set_m(1, 1'b1, 1'b0, 16'hBEEF);
    bus.p_in_cam_rd = 1'b1;
    #1;
    chk("rd_drxd1", bus.p_out_dbg_rxd, 16'hA5A5);
    chk("rd_crxd1", bus.p_out_cam_rxd, 16'h0000);
    tick;
    chk("rd_stray", bus.p_out_usr_rx_rd, 0);
    chk("rd_own", bus.p_out_owner, 2'b10);
    bus.p_in_cam_rd = 1'b0;
    set_m(1, 1'b0, 1'b1, 16'd0);
    tick;
    set_m(1, 1'b0, 1'b0, 16'd0);
    chk("rd_rx2", bus.p_out_usr_rx_rd, 1);
    bus.p_in_usr_rxd = 16'h5A5A;
    #1;
    chk("rd_drxd2", bus.p_out_dbg_rxd, 16'h5A5A);
    chk("rd_crxd2", bus.p_out_cam_rxd, 16'h0000);
    chk("rd_end_own", bus.p_out_owner, 2'b00);
    tick;
    chk("rd_after", bus.p_out_usr_rx_rd, 0);
    bus.p_in_usr_rxd = 16'h0000;

    // zero-length packet from camera
    set_m(0, 1'b1, 1'b0, 16'h0000);
    exp_q.push_back(16'h0000);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    tick;
    chk("n0_own", bus.p_out_owner, 2'b01);
    chk("n0_txwr", bus.p_out_usr_tx_wr, 1);
    tick;
    chk("n0_idle", bus.p_out_owner, 2'b00);
    chk("n0_txwr0", bus.p_out_usr_tx_wr, 0);

    // tie after a camera packet: debug wins
    set_m(0, 1'b1, 1'b0, 16'h0000);
    set_m(1, 1'b1, 1'b0, 16'h0100);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0000);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    set_m(1, 1'b0, 1'b0, 16'd0);
    tick;
    chk("rr_own_dbg", bus.p_out_owner, 2'b10);
    tick;
    chk("rr_idle", bus.p_out_owner, 2'b00);
    tick;
    chk("rr_own_cam", bus.p_out_owner, 2'b01);
    tick;
    chk("rr_done", bus.p_out_owner, 2'b00);

    // one payload word then silence
    set_m(0, 1'b1, 1'b0, 16'h0004);
    exp_q.push_back(16'h0004);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    wait_owner(2'b01);
    set_m(0, 1'b1, 1'b0, 16'hE000);
    exp_q.push_back(16'hE000);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    first = 0;
    pulses = 0;
    own_at_err = 2'b11;
    for (int k = 1; k <= 30; k++) begin
      if (bus.p_out_err === 1'b1) begin
        if (first == 0) begin
          first = k;
          own_at_err = bus.p_out_owner;
        end
        pulses++;
      end
      tick;
    end
`ifdef HDD_USRCFG_ARB_TIMEOUT_EN
    chk("to_cycle", first, TO + 1);
    chk("to_pulses", pulses, 1);
    chk("to_own_err", own_at_err, 2'b00);
    chk("to_own", bus.p_out_owner, 2'b00);
`else
    chk("noto_pulses", pulses, 0);
    chk("noto_own", bus.p_out_owner, 2'b01);
    for (int i = 1; i < 4; i++) begin
      set_m(0, 1'b1, 1'b0, 16'hE000 + 16'(i));
      exp_q.push_back(16'hE000 + 16'(i));
      tick;
    end
    set_m(0, 1'b0, 1'b0, 16'd0);
    chk("noto_done", bus.p_out_owner, 2'b00);
`endif
    tick;

    // reset in the middle of a write packet
    set_m(0, 1'b1, 1'b0, 16'h0005);
    exp_q.push_back(16'h0005);
    tick;
    set_m(0, 1'b0, 1'b0, 16'd0);
    wait_owner(2'b01);
    set_m(0, 1'b1, 1'b0, 16'hF000);
    exp_q.push_back(16'hF000);
    tick;
    set_m(0, 1'b1, 1'b0, 16'hF001);
    exp_q.push_back(16'hF001);
    tick;
    set_m(0, 1'b1, 1'b0, 16'hF002);
    rst_n = 1'b0;
    bus.p_in_usr_rxd = 16'h1234;
    tick;
    rst_n = 1'b1;
    set_m(0, 1'b0, 1'b0, 16'd0);
    chk_reset_vals("mid");
    tick;
    chk("mid_quiet", bus.p_out_usr_tx_wr, 0);
    bus.p_in_usr_rxd = 16'h0000;
    send_wr(1, 16'h0002, 16'h7700);
    repeat (3) tick;
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hdd_usrcfg_arb.md
# hdd_usrcfg_arb

Two-master arbiter for the 16-bit user command channel of the HDD subsystem (usr_tx_wr / usr_rx_rd / usr_txd / usr_rxd). It shares the channel between the camera control logic and the FTDI debug bridge, granting one master for a whole command packet. It sits between those two masters and the HDD core's user port, all in the user clock domain.

## Interface
- G_TIMEOUT, 1024: idle cycles allowed inside a granted packet before abort (2..65535).
- p_in_clk  in  1  user clock; all logic on rising edge.
- p_in_rst_n  in  1  synchronous, active-low reset.
- p_in_cam_wr  in  1  camera write strobe, one word per cycle high.
- p_in_cam_txd  in  16  camera write word.
- p_in_cam_rd  in  1  camera read strobe.
- p_out_cam_rxd  out  16  read data to camera.
- p_out_cam_busy  out  1  camera must not assert wr while high.
- p_in_dbg_wr, p_in_dbg_txd[15:0], p_in_dbg_rd, p_out_dbg_rxd[15:0], p_out_dbg_busy: same for the debug bridge.
- p_out_usr_tx_wr  out  1  write strobe to HDD core.
- p_out_usr_txd  out  16  write word to HDD core.
- p_out_usr_rx_rd  out  1  read strobe to HDD core.
- p_in_usr_rxd  in  16  read data from HDD core.
- p_out_owner  out  2  00 none, 01 camera, 10 debug.
- p_out_err  out  1  one-cycle pulse on timeout abort.

## Operation
- Packet format: first word is the header, with bit15 = dir (1 = read) and bits7:0 = N. Write packet: header plus N payload words. Read packet: header, then the owner issues N rd strobes.
- Each master has a 1-entry header holding register. A wr from a non-owner with an empty register loads it. That master's busy is high while its register is full and it is not the owner.
- A wr while busy is dropped. A rd from a non-owner is dropped. A non-owner's rxd is 0.
- FSM states: IDLE, HDR, XFER.
- IDLE: if any holding register is full, grant round-robin and go to HDR. On a simultaneous request, the master that was not the last owner wins. After reset the last owner is debug, so the camera wins the first tie.
- HDR (1 cycle): forward the header (tx_wr=1, txd=header) and clear that holding register. The word counter is loaded with N. If N=0, go to IDLE; else go to XFER.
- XFER, write: the owner's wr/txd are registered onto usr_tx_wr/usr_txd. The counter decrements per forwarded word. At 0, return to IDLE.
- XFER, read: the owner's rd is registered onto usr_rx_rd. The counter decrements per strobe. At 0, return to IDLE.
- XFER, wrong-direction strobe: a rd in a write packet, or a wr in a read packet, is dropped and does not count.
- The owner's busy is 0 for the whole packet.
- Owner rxd = p_in_usr_rxd (combinational mux on the owner register).
- owner = 00 in IDLE, and the granted master's code in HDR/XFER.
- Timeout: in XFER, an idle counter resets on every accepted strobe. When it reaches G_TIMEOUT-1 without a strobe, the FSM returns to IDLE, p_out_err pulses, and the remaining words are discarded (no strobes issued).

## Timing
- Reset values of the outputs:
  - p_out_usr_tx_wr=0, p_out_usr_txd=0, p_out_usr_rx_rd=0.
  - p_out_owner=00, p_out_err=0.
  - p_out_cam_busy=0, p_out_dbg_busy=0.
  - p_out_cam_rxd=0, p_out_dbg_rxd=0.
- State after reset: both holding registers are empty, FSM is in IDLE, last owner = debug.
- Reset mid-packet: the packet is abandoned with no further strobes.
- Header latency, empty channel: wr at cycle T loads the holding register at T+1 (busy rises at T+1). The grant is in IDLE at T+1. HDR puts the header on usr_txd at T+2.
- Payload write latency: owner wr at cycle T gives usr_tx_wr at T+1. Back-to-back payload words are forwarded at one per cycle.
- Read latency: owner rd at cycle T gives usr_rx_rd at T+1. The owner samples rxd per the HDD core's read latency; the arbiter adds none on the return path.
- Turnaround: after the last payload word or strobe, the FSM is in IDLE next cycle. A pending header from the other master is output 2 cycles after the last word.
- The owner must not send the header of its next packet until owner returns to 00. Such a word is treated as a fresh request.

## Configuration
- HDD_USRCFG_ARB_TIMEOUT_EN defined: the timeout watchdog and G_TIMEOUT are active, and p_out_err pulses on abort.
- HDD_USRCFG_ARB_TIMEOUT_EN undefined: no idle counter, the grant is held until N words complete, and p_out_err is tied 0.

## Test plan
- Camera write packet, header 0x0003 plus 3 words, debug idle: usr_tx_wr high for 4 cycles with header and words in order, starting 2 cycles after header wr. owner=01 throughout, then 00.
- Camera and debug headers in the same cycle just after reset: camera is served first. Debug busy=1 until its header is forwarded 2 cycles after camera's last word. owner then =10.
- Debug read packet 0x8002 with 2 rd strobes, usr_rxd=0xA5A5/0x5A5A: 2 usr_rx_rd pulses each 1 cycle after the strobe. dbg_rxd shows the data and cam_rxd stays 0.
- Header N=0 (0x0000): one usr_tx_wr, then owner=00 on the next cycle, with no XFER.
- Timeout enabled, G_TIMEOUT=16, camera header 0x0004 then 1 word then silence: err pulses once, 16 idle cycles after that word. owner=00 and no further tx_wr.
- Reset asserted mid-XFER: next cycle all outputs at reset values. A new debug packet afterwards completes normally.
